hazard_stall_ctrl: RTL

//  Pipeline hazard controller for the 5-stage RV32IM core. Drives PC_en and the en/sync_rst pins of
//  IF/ID, ID/EX, EX/MEM and MEM/WB from ID/EX-stage hazard inputs. Generates the load-use bubble
//  and the taken-branch flush, and sequences multi-cycle MUL/DIV ops held in EX with a FSM + counter.

---
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and multi-cycle MUL/DIV sequencing.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_cycles performance counter ports.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        ID_R1_read,
    input  logic        ID_R2_read,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        EX_mem_read,
    input  logic [4:0]  EX_rd,
    input  logic        EX_redirect,
    input  logic        EX_md_op,
    output logic        PC_en,
    output logic        IF_ID_en,
    output logic        IF_ID_sync_rst,
    output logic        ID_EX_en,
    output logic        ID_EX_sync_rst,
    output logic        EX_MEM_en,
    output logic        EX_MEM_sync_rst,
    output logic        MEM_WB_en,
    output logic        MEM_WB_sync_rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic        md_busy,
    output logic        md_done
);

    localparam int unsigned CntW = $clog2(MD_LATENCY + 1);

    typedef enum logic {StRun, StMdBusy} st_e;

    st_e            st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            md_stall;

    assign load_use = EX_mem_read && (EX_rd != 5'd0) &&
                      ((ID_R1_read && (ID_rs1 == EX_rd)) || (ID_R2_read && (ID_rs2 == EX_rd)));

    assign md_stall = ((st_q == StRun) && EX_md_op && (MD_LATENCY > 1)) ||
                      ((st_q == StMdBusy) && (cnt_q != '0));

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            st_q  <= StRun;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d            = st_q;
        cnt_d           = cnt_q;
        md_done         = 1'b0;
        PC_en           = 1'b1;
        IF_ID_en        = 1'b1;
        IF_ID_sync_rst  = 1'b0;
        ID_EX_en        = 1'b1;
        ID_EX_sync_rst  = 1'b0;
        EX_MEM_en       = 1'b1;
        EX_MEM_sync_rst = 1'b0;
        MEM_WB_en       = 1'b1;
        MEM_WB_sync_rst = 1'b0;

        unique case (st_q)
            StRun: begin
                if (MD_LATENCY > 1) begin
                    if (EX_md_op && !EX_redirect) begin
                        st_d  = StMdBusy;
                        cnt_d = CntW'(MD_LATENCY - 2);
                    end
                end else begin
                    // Single-cycle MD unit: result is ready in the same cycle
                    md_done = EX_md_op;
                end
            end
            StMdBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    st_d    = StRun;
                    md_done = 1'b1;
                end
            end
            default: st_d = StRun;
        endcase

        if (EX_redirect) begin
            IF_ID_sync_rst = 1'b1;
            ID_EX_sync_rst = 1'b1;
        end else if (md_stall) begin
            PC_en           = 1'b0;
            IF_ID_en        = 1'b0;
            ID_EX_en        = 1'b0;
            EX_MEM_sync_rst = 1'b1;
        end else if (load_use) begin
            PC_en          = 1'b0;
            IF_ID_en       = 1'b0;
            ID_EX_sync_rst = 1'b1;
        end

        // Hold every stage cleared while reset is asserted
        if (!async_rst) begin
            md_done         = 1'b0;
            PC_en           = 1'b0;
            IF_ID_en        = 1'b0;
            IF_ID_sync_rst  = 1'b1;
            ID_EX_en        = 1'b0;
            ID_EX_sync_rst  = 1'b1;
            EX_MEM_en       = 1'b0;
            EX_MEM_sync_rst = 1'b1;
            MEM_WB_en       = 1'b0;
            MEM_WB_sync_rst = 1'b1;
        end
    end

    assign md_busy = (st_q == StMdBusy);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!PC_en) begin
            stall_d = stall_q + 32'd1;
        end
        if (EX_redirect) begin
            flush_d = flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`endif

endmodule
